// File: rtl/demux14_buf.sv
// 1-to-4 demultiplexer with a single-entry output buffer and delivery counter per channel.
// Latency: 1 cycle from input accept to o_valid_k; a full buffer refills on its drain cycle with no bubble.
// Backpressure: o_ready drops only when the selected channel is full and its consumer is not ready.
module demux14_buf #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  input  logic [1:0]   i_sel,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_y_0,
  output logic [W-1:0] o_y_1,
  output logic [W-1:0] o_y_2,
  output logic [W-1:0] o_y_3,
  output logic         o_valid_0,
  output logic         o_valid_1,
  output logic         o_valid_2,
  output logic         o_valid_3,
  input  logic         i_ready_0,
  input  logic         i_ready_1,
  input  logic         i_ready_2,
  input  logic         i_ready_3,
  output logic [7:0]   o_cnt_0,
  output logic [7:0]   o_cnt_1,
  output logic [7:0]   o_cnt_2,
  output logic [7:0]   o_cnt_3
);

  logic [W-1:0] data_q [4];
  logic [W-1:0] data_d [4];
  logic [3:0]   full_q;
  logic [3:0]   full_d;
  logic [7:0]   cnt_q  [4];
  logic [7:0]   cnt_d  [4];
  logic [3:0]   rdy_in;
  logic [3:0]   drain;
  logic         accept;

  assign rdy_in = {i_ready_3, i_ready_2, i_ready_1, i_ready_0};

  // Input handshake: the selected slot can take a word if empty or draining this cycle.
  // Reset gating keeps o_ready low for the whole time i_rst_n is asserted.
  always_comb begin
    o_ready = i_rst_n & (~full_q[i_sel] | rdy_in[i_sel]);
    accept  = i_valid & o_ready;
    drain   = full_q & rdy_in;
  end

  // Per-channel next state: drain first, then a same-cycle accept overrides the clear.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      data_d[k] = data_q[k];
      full_d[k] = full_q[k];
      cnt_d[k]  = cnt_q[k];
      if (drain[k]) begin
        full_d[k] = 1'b0;
        cnt_d[k]  = cnt_q[k] + 8'd1;
      end
      if (accept && (i_sel == 2'(k))) begin
        data_d[k] = i_d;
        full_d[k] = 1'b1;
      end
    end
  end

  // State registers; reset drops any buffered word and zeroes data and counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  assign o_y_0     = data_q[0];
  assign o_y_1     = data_q[1];
  assign o_y_2     = data_q[2];
  assign o_y_3     = data_q[3];
  assign o_valid_0 = full_q[0];
  assign o_valid_1 = full_q[1];
  assign o_valid_2 = full_q[2];
  assign o_valid_3 = full_q[3];
  assign o_cnt_0   = cnt_q[0];
  assign o_cnt_1   = cnt_q[1];
  assign o_cnt_2   = cnt_q[2];
  assign o_cnt_3   = cnt_q[3];

endmodule

// File: doc/demux14_buf.md
DEMUX14_BUF -- requirements
Module: demux14_buf

Interface
REQ-001 Parameter: W, default 8, data width of the input stream and of each output channel.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_d  input  W  input data word.
REQ-005 i_sel  input  2  destination channel for i_d (00->0, 01->1, 10->2, 11->3).
REQ-006 i_valid  input  1  i_d and i_sel valid this cycle.
REQ-007 o_ready  output  1  block accepts i_d this cycle.
REQ-008 o_y_0..o_y_3  output  W each  channel k output data.
REQ-009 o_valid_0..o_valid_3  output  1 each  channel k holds an undelivered word.
REQ-010 i_ready_0..i_ready_3  input  1 each  channel k consumer accepts this cycle.
REQ-011 o_cnt_0..o_cnt_3  output  8 each  count of words delivered on channel k.

Function
REQ-012 The block SHALL contain one single-entry buffer per channel: a W-bit data register and a full flag; o_y_k is the data register and o_valid_k is the full flag.
REQ-013 The block SHALL define input accept as i_valid & o_ready, and channel k drain as o_valid_k & i_ready_k.
REQ-014 o_ready SHALL be combinational: !full[i_sel] | i_ready[i_sel], forced 0 while i_rst_n is low.
REQ-015 On accept, the block SHALL load i_d into buffer[i_sel] and set full[i_sel]; o_valid goes high on the following cycle (latency 1).
REQ-016 On drain of channel k without an accept to k in the same cycle, the block SHALL clear full[k].
REQ-017 On a drain of channel k and an accept to k in the same cycle, the block SHALL load the new word and keep full[k]=1, with no bubble.
REQ-018 Accept to channel j and drain of channel k (j!=k) in the same cycle SHALL both take effect independently; all four channels may drain in one cycle.
REQ-019 When full[i_sel]=1 and i_ready[i_sel]=0, o_ready SHALL be 0, and no buffer SHALL change from the input side.
REQ-020 A full buffer on one channel SHALL NOT block accepts to other channels.
REQ-021 i_sel and i_d SHALL be ignored when i_valid=0.
REQ-022 Data registers SHALL hold their last value after a drain; they are not cleared.
REQ-023 Words to the same channel SHALL be delivered in acceptance order; no word is dropped or duplicated.
REQ-024 o_cnt_k SHALL increment by 1 on each drain of channel k, wrapping 255->0 with no flag.
REQ-025 i_ready_k while o_valid_k=0 SHALL have no effect, and the counter SHALL NOT increment.
REQ-026 The output o_valid_k SHALL NOT depend combinationally on i_ready_k.

Reset
REQ-027 Asserting i_rst_n low SHALL immediately clear all full flags, o_y_0..3 to 0, o_valid_0..3 to 0, o_cnt_0..3 to 0, and o_ready to 0, regardless of i_clk.
REQ-028 A reset during a transfer SHALL discard any buffered word, and SHALL NOT deliver it after release.
REQ-029 After i_rst_n rises, o_ready SHALL be 1 in the first cycle; the first accept SHALL be on the first rising edge with i_rst_n=1.

Verification
REQ-030 Basic routing: all i_ready_k=1; send i_d=0x11,0x22,0x33,0x44 with i_sel=0,1,2,3 in consecutive cycles -> each o_valid_k pulses for one cycle, 1 cycle after its accept, with o_y_k equal to the matching word; o_cnt_k=1 each.
REQ-031 Backpressure: i_ready_2=0; send 0xA5 then 0x5A to i_sel=2 -> first accepted, o_ready=0 for second, o_y_2=0xA5 held; raise i_ready_2 -> 0xA5 drained and 0x5A accepted in the same cycle, then 0x5A delivered.
REQ-032 Isolation: channel 1 full with i_ready_1=0; stream 8 words to channel 3 with i_ready_3=1 -> all 8 accepted back-to-back, o_cnt_3=8, and o_cnt_1=0.
REQ-033 Counter wrap: 256 drains on channel 0 -> o_cnt_0 reads 255 then 0.
REQ-034 Reset mid-operation: channels 0 and 3 full; pulse i_rst_n low between clock edges -> all o_valid and o_cnt are 0 and o_ready=0 at once, with no stale word delivered after release.
REQ-035 Random: random i_valid, i_sel, and i_ready_k over 10k cycles -> a scoreboard with per-channel queues matches every delivered word and its order, and o_cnt_k matches the delivered count mod 256.
